// File: rtl/tx_intf_pkg.sv
// Shared definitions for the TX accelerator streaming path: FSM encoding,
// antenna packing modes and default DAC word geometry.
package tx_intf_pkg;

  localparam int DAC_PACK_DATA_WIDTH = 64;
  localparam int IQ_WIDTH            = DAC_PACK_DATA_WIDTH / 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEL_ON = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_TAIL   = 3'd4;

  // Encoding 3 is not listed and falls back to ANT0_ONLY behaviour.
  typedef enum logic [1:0] {
    ANT0_ONLY = 2'd0,
    ANT_DUP   = 2'd1,
    ANT1_ONLY = 2'd2
  } ant_mode_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO with a registered head; push and pop may
// coincide, and a push while full is only taken if a pop frees a slot.
module skid_fifo2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q <= '0;
      end else if (do_push && (wr_ptr_q == 1'(gi))) begin
        data_q <= push_data_i;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = rd_ptr_q ? g_slot[1].data_q : g_slot[0].data_q;
  assign count_o = count_q;

endmodule

// File: rtl/tx_iq_streamer.sv
// Accelerator-side source for the DAC FIFO: claims the path via src_sel,
// waits out the select synchroniser, packs IQ samples into two-antenna words.
module tx_iq_streamer #(
  parameter int DAC_PACK_DATA_WIDTH = tx_intf_pkg::DAC_PACK_DATA_WIDTH,
  parameter int IQ_WIDTH            = tx_intf_pkg::IQ_WIDTH,
  parameter int LEN_WIDTH           = 16,
  parameter int GUARD_CYCLES        = 8,
  parameter int TAIL_CYCLES         = 64
) (
  input  logic                           acc_clk,
  input  logic                           acc_rstn,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           num_samples,
  input  logic [1:0]                     ant_mode,
  input  logic [IQ_WIDTH-1:0]            s_iq_data,
  input  logic                           s_iq_valid,
  output logic                           s_iq_ready,
  output logic [DAC_PACK_DATA_WIDTH-1:0] data_from_acc,
  output logic                           data_valid_from_acc,
  input  logic                           fulln_to_acc,
  output logic                           src_sel,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    underrun_cnt
);

  import tx_intf_pkg::*;

  // One timer serves both the guard and the tail hold; they never overlap.
  localparam int TMR_MAX = (GUARD_CYCLES > TAIL_CYCLES) ? GUARD_CYCLES : TAIL_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [2:0]                     state_q, state_d;
  logic [TMR_W-1:0]               timer_q, timer_d;
  logic [LEN_WIDTH-1:0]           remaining_q, remaining_d;
  logic [1:0]                     mode_q, mode_d;
  logic [15:0]                    underrun_q, underrun_d;
  logic                           done_q, done_d;

  logic                           accept;
  logic [DAC_PACK_DATA_WIDTH-1:0] packed_word;
  logic [DAC_PACK_DATA_WIDTH-1:0] skid_head;
  logic [1:0]                     skid_count;

  assign s_iq_ready = (state_q == ST_STREAM) && (skid_count < 2'd2) &&
                      (remaining_q != '0);
  assign accept     = s_iq_valid && s_iq_ready;

  always_comb begin
    packed_word = '0;
    case (mode_q)
      ANT_DUP:   packed_word = {s_iq_data, s_iq_data};
      ANT1_ONLY: packed_word = {s_iq_data, {IQ_WIDTH{1'b0}}};
      default:   packed_word = {{IQ_WIDTH{1'b0}}, s_iq_data};
    endcase
  end

  skid_fifo2 #(
    .WIDTH (DAC_PACK_DATA_WIDTH)
  ) u_skid (
    .clk_i       (acc_clk),
    .rst_ni      (acc_rstn),
    .push_i      (accept),
    .push_data_i (packed_word),
    .pop_i       (data_valid_from_acc),
    .head_o      (skid_head),
    .count_o     (skid_count)
  );

  assign data_valid_from_acc = (skid_count != 2'd0) && fulln_to_acc;
  assign data_from_acc       = skid_head;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_samples != '0) begin
            remaining_d = num_samples;
            mode_d      = ant_mode;
            underrun_d  = '0;
            timer_d     = '0;
            state_d     = ST_SEL_ON;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SEL_ON: begin
        if (timer_q == TMR_W'(GUARD_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ST_STREAM;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STREAM: begin
        if (accept) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
        end
        // Starved: work left, nothing buffered and nothing offered.
        if ((remaining_q != '0) && (skid_count == 2'd0) && !s_iq_valid &&
            (underrun_q != 16'hFFFF)) begin
          underrun_d = underrun_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        // Leave as the last word goes out so the tail counts from that write.
        if ((skid_count == 2'd0) ||
            ((skid_count == 2'd1) && data_valid_from_acc)) begin
          timer_d = '0;
          state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (timer_q == TMR_W'(TAIL_CYCLES - 1)) begin
          timer_d = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge acc_clk or negedge acc_rstn) begin
    if (!acc_rstn) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      mode_q      <= 2'd0;
      underrun_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign src_sel      = busy;
  assign done         = done_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_tx_iq_streamer.sv
// Directed bench for tx_iq_streamer: cycle-accurate checks relative to the
// start cycle (rel 0) for run timing, packing, backpressure and underrun.
module tb_tx_iq_streamer;

  logic        acc_clk;
  logic        acc_rstn;
  logic        start;
  logic [15:0] num_samples;
  logic [1:0]  ant_mode;
  logic [31:0] s_iq_data;
  logic        s_iq_valid;
  logic        s_iq_ready;
  logic [63:0] data_from_acc;
  logic        data_valid_from_acc;
  logic        fulln_to_acc;
  logic        src_sel;
  logic        busy;
  logic        done;
  logic [15:0] underrun_cnt;

  tx_iq_streamer dut (
    .acc_clk             (acc_clk),
    .acc_rstn            (acc_rstn),
    .start               (start),
    .num_samples         (num_samples),
    .ant_mode            (ant_mode),
    .s_iq_data           (s_iq_data),
    .s_iq_valid          (s_iq_valid),
    .s_iq_ready          (s_iq_ready),
    .data_from_acc       (data_from_acc),
    .data_valid_from_acc (data_valid_from_acc),
    .fulln_to_acc        (fulln_to_acc),
    .src_sel             (src_sel),
    .busy                (busy),
    .done                (done),
    .underrun_cnt        (underrun_cnt)
  );

  initial acc_clk = 1'b0;
  always #5 acc_clk = ~acc_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] samples [4];
  int fl_s, fl_n, vg_s, vg_n;
  logic ready_log [256];
  logic src_log   [256];
  logic busy_log  [256];
  int          wr_rel [$];
  logic [63:0] wr_dat [$];
  int          done_rel [$];
  int          wr_while_full;

  // Drives one run; rel 0 is the cycle carrying start. Records per-cycle
  // observations sampled on the falling edge.
  task automatic drive_run(input logic [15:0] n, input logic [1:0] mode,
                           input int ncyc, input int restart_at);
    int   idx;
    logic acc;
    idx = 0;
    wr_rel.delete(); wr_dat.delete(); done_rel.delete(); wr_while_full = 0;
    for (int r = 0; r < ncyc; r++) begin
      start        = (r == 0) || (r == restart_at);
      num_samples  = (r == restart_at) ? 16'd2 : n;
      ant_mode     = (r == restart_at) ? 2'd0 : mode;
      fulln_to_acc = !((r >= fl_s) && (r < fl_s + fl_n));
      s_iq_valid   = (idx < 4) && !((r >= vg_s) && (r < vg_s + vg_n));
      s_iq_data    = samples[(idx < 4) ? idx : 3];
      @(negedge acc_clk);
      ready_log[r] = s_iq_ready;
      src_log[r]   = src_sel;
      busy_log[r]  = busy;
      if (data_valid_from_acc) begin
        wr_rel.push_back(r);
        wr_dat.push_back(data_from_acc);
        if (!fulln_to_acc) wr_while_full++;
        $display("  write rel=%0d data=%h", r, data_from_acc);
      end
      if (done) begin
        done_rel.push_back(r);
        $display("  done  rel=%0d", r);
      end
      acc = s_iq_valid && s_iq_ready;
      @(posedge acc_clk); #1;
      if (acc) idx++;
    end
    start = 1'b0; s_iq_valid = 1'b0; fulln_to_acc = 1'b1;
  endtask

  task automatic test_reset();
    acc_rstn = 1'b0;
    repeat (3) @(posedge acc_clk);
    @(negedge acc_clk);
    n_checks++;
    if ({src_sel, s_iq_ready, data_valid_from_acc, busy, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b need 00000",
               {src_sel, s_iq_ready, data_valid_from_acc, busy, done});
    end
    n_checks++;
    if ({data_from_acc, underrun_cnt} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h under=%h need 0", data_from_acc, underrun_cnt);
    end
    @(posedge acc_clk); #1;
    acc_rstn = 1'b1;
    @(posedge acc_clk); #1;
  endtask

  task automatic test_basic(input string tag);
    logic [63:0] got;
    int          gi;
    drive_run(16'd4, 2'd1, 90, -1);
    n_checks++;
    if ({src_log[0], src_log[1], busy_log[1]} !== 3'b011) begin
      n_fail++;
      $display("FAIL %s sel_rise: got c0/c1/busy=%b need 011", tag,
               {src_log[0], src_log[1], busy_log[1]});
    end
    n_checks++;
    if ({ready_log[8], ready_log[9]} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s ready_start: got c8/c9=%b need 01", tag, {ready_log[8], ready_log[9]});
    end
    n_checks++;
    if (wr_rel.size() !== 4) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d need 4", tag, wr_rel.size());
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < wr_dat.size()) ? wr_dat[k] : 64'hx;
      gi  = (k < wr_rel.size()) ? wr_rel[k] : -1;
      n_checks++;
      if (got !== {samples[k], samples[k]} || gi !== 10 + k) begin
        n_fail++;
        $display("FAIL %s word%0d: got %h at %0d need %h at %0d", tag, k, got, gi,
                 {samples[k], samples[k]}, 10 + k);
      end
    end
    gi = (done_rel.size() > 0) ? done_rel[0] : -1;
    n_checks++;
    if (done_rel.size() !== 1 || gi !== 78) begin
      n_fail++;
      $display("FAIL %s done_time: got %0d pulses first at %0d need 1 at 78", tag,
               done_rel.size(), gi);
    end
    n_checks++;
    if ({src_log[77], src_log[78]} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s sel_fall: got c77/c78=%b need 10", tag, {src_log[77], src_log[78]});
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] got;
    int          gi;
    fl_s = 10; fl_n = 5;
    drive_run(16'd4, 2'd0, 100, -1);
    fl_s = -1; fl_n = 0;
    n_checks++;
    if (wr_while_full !== 0 || wr_rel.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_writes: got %0d while full, %0d total need 0 and 4",
               wr_while_full, wr_rel.size());
    end
    n_checks++;
    if ({ready_log[10], ready_log[11], ready_log[14], ready_log[15], ready_log[16]} !== 5'b10001) begin
      n_fail++;
      $display("FAIL bp_ready: got c10/11/14/15/16=%b need 10001",
               {ready_log[10], ready_log[11], ready_log[14], ready_log[15], ready_log[16]});
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < wr_dat.size()) ? wr_dat[k] : 64'hx;
      gi  = (k < wr_rel.size()) ? wr_rel[k] : -1;
      n_checks++;
      if (got !== {32'h0, samples[k]} || gi !== 15 + k) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %h at %0d need %h at %0d", k, got, gi,
                 {32'h0, samples[k]}, 15 + k);
      end
    end
    gi = (done_rel.size() > 0) ? done_rel[0] : -1;
    n_checks++;
    if (gi !== 83) begin
      n_fail++;
      $display("FAIL bp_done: got %0d need 83", gi);
    end
  endtask

  task automatic test_underrun();
    logic [63:0] got;
    int          gi;
    vg_s = 10; vg_n = 4;
    drive_run(16'd4, 2'd0, 100, -1);
    vg_s = -1; vg_n = 0;
    n_checks++;
    if (underrun_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL ur_count: got %0d need 3", underrun_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < wr_dat.size()) ? wr_dat[k] : 64'hx;
      gi  = (k < wr_rel.size()) ? wr_rel[k] : -1;
      n_checks++;
      if (got !== {32'h0, samples[k]} || gi !== ((k == 0) ? 10 : 14 + k)) begin
        n_fail++;
        $display("FAIL ur_word%0d: got %h at %0d need %h at %0d", k, got, gi,
                 {32'h0, samples[k]}, (k == 0) ? 10 : 14 + k);
      end
    end
    gi = (done_rel.size() > 0) ? done_rel[0] : -1;
    n_checks++;
    if (gi !== 82) begin
      n_fail++;
      $display("FAIL ur_done: got %0d need 82", gi);
    end
  endtask

  task automatic test_zero_length();
    logic any_sel;
    int   gi;
    drive_run(16'd0, 2'd0, 6, -1);
    any_sel = 1'b0;
    for (int r = 0; r < 6; r++) any_sel = any_sel | src_log[r] | busy_log[r];
    gi = (done_rel.size() > 0) ? done_rel[0] : -1;
    n_checks++;
    if (done_rel.size() !== 1 || gi !== 1) begin
      n_fail++;
      $display("FAIL zl_done: got %0d pulses first at %0d need 1 at 1", done_rel.size(), gi);
    end
    n_checks++;
    if (any_sel !== 1'b0 || wr_rel.size() !== 0) begin
      n_fail++;
      $display("FAIL zl_idle: got sel/busy=%b writes=%0d need 0 0", any_sel, wr_rel.size());
    end
  endtask

  task automatic test_mode2_busy_start();
    logic [63:0] got;
    int          gi;
    drive_run(16'd4, 2'd2, 100, 11);
    n_checks++;
    if (wr_rel.size() !== 4) begin
      n_fail++;
      $display("FAIL m2_count: got %0d need 4", wr_rel.size());
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < wr_dat.size()) ? wr_dat[k] : 64'hx;
      n_checks++;
      if (got !== {samples[k], 32'h0}) begin
        n_fail++;
        $display("FAIL m2_word%0d: got %h need %h", k, got, {samples[k], 32'h0});
      end
    end
    gi = (done_rel.size() > 0) ? done_rel[0] : -1;
    n_checks++;
    if (done_rel.size() !== 1 || gi !== 78 || busy_log[79] !== 1'b0) begin
      n_fail++;
      $display("FAIL m2_done: got %0d pulses first at %0d busy79=%b need 1 at 78 busy 0",
               done_rel.size(), gi, busy_log[79]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    vg_s = 10; vg_n = 4;
    drive_run(16'd4, 2'd1, 14, -1);
    vg_s = -1; vg_n = 0;
    n_checks++;
    if (underrun_cnt !== 16'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre: got under=%0d busy=%b need 3 1", underrun_cnt, busy);
    end
    acc_rstn = 1'b0;
    #1;
    n_checks++;
    if ({src_sel, s_iq_ready, data_valid_from_acc, busy, done} !== 5'b0 ||
        data_from_acc !== 64'h0 || underrun_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL rm_async: got ctl=%b data=%h under=%h need all 0",
               {src_sel, s_iq_ready, data_valid_from_acc, busy, done}, data_from_acc, underrun_cnt);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge acc_clk);
      saw_done = saw_done | done;
    end
    @(posedge acc_clk); #1;
    acc_rstn = 1'b1;
    repeat (3) begin
      @(negedge acc_clk);
      saw_done = saw_done | done;
    end
    @(posedge acc_clk); #1;
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_no_done: got done=%b need 0", saw_done);
    end
    test_basic("after_reset");
  endtask

  initial begin
    samples[0] = 32'h11112222;
    samples[1] = 32'h22223333;
    samples[2] = 32'h33334444;
    samples[3] = 32'h44445555;
    fl_s = -1; fl_n = 0; vg_s = -1; vg_n = 0;
    start = 1'b0; num_samples = 16'd0; ant_mode = 2'd0;
    s_iq_data = 32'h0; s_iq_valid = 1'b0; fulln_to_acc = 1'b1;

    test_reset();
    test_basic("basic");
    test_backpressure();
    test_underrun();
    test_zero_length();
    test_mode2_busy_start();
    test_reset_mid_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
